// File: rtl/proc_pkg.sv
// Shared definitions for the accumulator processor: opcodes, bus selects, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_pkg;

    localparam int DW        = 16;
    localparam int AW        = 6;
    localparam int MEM_DEPTH = 64;
    localparam int NREG      = 8;

    typedef logic [DW-1:0] word_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MOV   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;
    localparam logic [2:0] OP_INC   = 3'd6;
    localparam logic [2:0] OP_JMPZ  = 3'd7;

    localparam logic [2:0] SEL_AR  = 3'd0;
    localparam logic [2:0] SEL_PC  = 3'd1;
    localparam logic [2:0] SEL_DR  = 3'd2;
    localparam logic [2:0] SEL_RA  = 3'd3;
    localparam logic [2:0] SEL_RB  = 3'd4;
    localparam logic [2:0] SEL_RC  = 3'd5;
    localparam logic [2:0] SEL_TR  = 3'd6;
    localparam logic [2:0] SEL_MEM = 3'd7;

    // Register-file slot 7 holds AC: sel 7 means MEM on the bus and for STORE,
    // but means AC for INC, so parking AC there makes INC a plain indexed update.
    localparam logic [2:0] REG_AC = 3'd7;

    // Ops that drive the internal bus onto A_bus/MUX_out.
    function automatic logic reads_bus(input logic [2:0] op);
        return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_JMPZ);
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Accumulator ALU: MOV/ADD/SUB/AND of AC with the bus value, plus zero detect.
// Latency: combinational.
// Backpressure: none.
// Ports: op (3b opcode), ac/bus (16b operands) -> result (16b), zero.
module proc_alu
    import proc_pkg::*;
(
    input  logic [2:0] op,
    input  word_t      ac,
    input  word_t      bus,
    output word_t      result,
    output logic       zero
);

    always_comb begin
        result = ac;
        case (op)
            OP_MOV:  result = bus;
            OP_ADD:  result = ac + bus;
            OP_SUB:  result = ac - bus;
            OP_AND:  result = ac & bus;
            default: result = ac;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/processor_top.sv
// Single-cycle 16-bit accumulator processor: decoder, bus mux, register file, 64x16 RAM.
// Latency: one instruction per clock; registered results visible one cycle after IR.
// Backpressure: none; an instruction is consumed every clock.
// Ports: clk/rst (sync, active-high); IR instruction in; A_bus/MUX_out/write combinational
// bus observation; Z_Flag, out (TR), counter_in (last IR), AC_out, PC_out, ram_addr (AR) registered.
module processor_top
    import proc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    IR,
    output logic [3:0]    A_bus,
    output logic [DW-1:0] MUX_out,
    output logic          write,
    output logic          Z_Flag,
    output logic [DW-1:0] out,
    output logic [5:0]    counter_in,
    output logic [DW-1:0] AC_out,
    output logic [DW-1:0] PC_out,
    output logic [DW-1:0] ram_addr
);

    logic [2:0]    op;
    logic [2:0]    sel;
    logic [AW-1:0] mem_addr;
    logic          bus_rd;
    word_t         bus;
    word_t         alu_res;
    logic          alu_zero;

    // Slots 0..6 follow the sel encoding (AR, PC, DR, RA, RB, RC, TR); slot 7 is AC.
    word_t      regs_q [NREG];
    word_t      regs_d [NREG];
    word_t      mem_q  [MEM_DEPTH];
    word_t      mem_d  [MEM_DEPTH];
    logic       z_q, z_d;
    logic [5:0] counter_q, counter_d;

    assign op       = IR[5:3];
    assign sel      = IR[2:0];
    assign mem_addr = regs_q[SEL_AR][AW-1:0];
    assign bus      = (sel == SEL_MEM) ? mem_q[mem_addr] : regs_q[sel];
    assign bus_rd   = reads_bus(op);

    assign A_bus   = bus_rd ? {1'b1, sel} : 4'b0000;
    assign MUX_out = bus_rd ? bus : '0;
    assign write   = (op == OP_STORE) && (sel == SEL_MEM);

    proc_alu u_alu (
        .op     (op),
        .ac     (regs_q[REG_AC]),
        .bus    (bus),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        regs_d    = regs_q;
        mem_d     = mem_q;
        z_d       = z_q;
        counter_d = IR;
        // Default PC advance; STORE PC and a taken JMPZ override it, and
        // INC PC leaves it alone so the net effect is a single +1.
        regs_d[SEL_PC] = regs_q[SEL_PC] + 16'd1;
        case (op)
            OP_MOV, OP_ADD, OP_SUB, OP_AND: begin
                regs_d[REG_AC] = alu_res;
                z_d            = alu_zero;
            end
            OP_STORE: begin
                if (sel == SEL_MEM) begin
                    mem_d[mem_addr] = regs_q[REG_AC];
                end else begin
                    regs_d[sel] = regs_q[REG_AC];
                end
            end
            OP_INC: begin
                if (sel != SEL_PC) begin
                    regs_d[sel] = regs_q[sel] + 16'd1;
                end
            end
            OP_JMPZ: begin
                if (z_q) begin
                    regs_d[SEL_PC] = bus;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            z_q       <= 1'b0;
            counter_q <= '0;
        end else begin
            regs_q    <= regs_d;
            mem_q     <= mem_d;
            z_q       <= z_d;
            counter_q <= counter_d;
        end
    end

    assign Z_Flag     = z_q;
    assign out        = regs_q[SEL_TR];
    assign counter_in = counter_q;
    assign AC_out     = regs_q[REG_AC];
    assign PC_out     = regs_q[SEL_PC];
    assign ram_addr   = regs_q[SEL_AR];

endmodule

// File: tb/tb_processor_top.sv
module tb_processor_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  IR;
    logic [3:0]  A_bus;
    logic [15:0] MUX_out;
    logic        write;
    logic        Z_Flag;
    logic [15:0] out;
    logic [5:0]  counter_in;
    logic [15:0] AC_out;
    logic [15:0] PC_out;
    logic [15:0] ram_addr;

    processor_top dut (
        .clk        (clk),
        .rst        (rst),
        .IR         (IR),
        .A_bus      (A_bus),
        .MUX_out    (MUX_out),
        .write      (write),
        .Z_Flag     (Z_Flag),
        .out        (out),
        .counter_in (counter_in),
        .AC_out     (AC_out),
        .PC_out     (PC_out),
        .ram_addr   (ram_addr)
    );

    always #25 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference machine state, named by architectural register.
    logic [15:0] m_pc, m_ac, m_ar, m_dr, m_ra, m_rb, m_rc, m_tr;
    logic        m_z;
    logic [5:0]  m_cnt;
    logic [15:0] m_mem [64];

    // Comb outputs sampled mid-cycle, and what the model expected for them.
    logic [3:0]  s_abus, e_abus;
    logic [15:0] s_mux, e_mux;
    logic        s_wr, e_wr;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_bus(input logic [2:0] s);
        case (s)
            3'd0: return m_ar;
            3'd1: return m_pc;
            3'd2: return m_dr;
            3'd3: return m_ra;
            3'd4: return m_rb;
            3'd5: return m_rc;
            3'd6: return m_tr;
            default: return m_mem[m_ar[5:0]];
        endcase
    endfunction

    task automatic m_reset();
        {m_pc, m_ac, m_ar, m_dr, m_ra, m_rb, m_rc, m_tr} = '0;
        m_z   = 1'b0;
        m_cnt = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
    endtask

    task automatic m_exec(input logic [5:0] ir);
        logic [2:0]  op, s;
        logic [15:0] b, npc, v;
        op  = ir[5:3];
        s   = ir[2:0];
        b   = m_bus(s);
        npc = m_pc + 16'd1;
        case (op)
            3'd1: begin m_ac = b;        m_z = (m_ac == 0); end
            3'd2: begin m_ac = m_ac + b; m_z = (m_ac == 0); end
            3'd3: begin m_ac = m_ac - b; m_z = (m_ac == 0); end
            3'd4: begin m_ac = m_ac & b; m_z = (m_ac == 0); end
            3'd5: begin
                v = m_ac;
                case (s)
                    3'd0: m_ar = v;
                    3'd1: npc  = v;
                    3'd2: m_dr = v;
                    3'd3: m_ra = v;
                    3'd4: m_rb = v;
                    3'd5: m_rc = v;
                    3'd6: m_tr = v;
                    default: m_mem[m_ar[5:0]] = v;
                endcase
            end
            3'd6: begin
                case (s)
                    3'd0: m_ar = m_ar + 1;
                    3'd1: ;  // INC PC is just the normal advance
                    3'd2: m_dr = m_dr + 1;
                    3'd3: m_ra = m_ra + 1;
                    3'd4: m_rb = m_rb + 1;
                    3'd5: m_rc = m_rc + 1;
                    3'd6: m_tr = m_tr + 1;
                    default: m_ac = m_ac + 1;
                endcase
            end
            3'd7: if (m_z) npc = b;
            default: ;
        endcase
        m_pc  = npc;
        m_cnt = ir;
    endtask

    // Drive one instruction for one cycle; sample comb outputs, clock, advance model.
    task automatic apply(input logic [5:0] ir, input logic r);
        logic rd;
        IR  = ir;
        rst = r;
        rd  = ir[5:3] inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        e_abus = rd ? {1'b1, ir[2:0]} : 4'b0;
        e_mux  = rd ? m_bus(ir[2:0]) : 16'h0;
        e_wr   = (ir == 6'b101111);
        #10;
        s_abus = A_bus;
        s_mux  = MUX_out;
        s_wr   = write;
        @(posedge clk);
        #1;
        if (r) m_reset();
        else   m_exec(ir);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".A_bus"},      {12'h0, s_abus}, {12'h0, e_abus});
        chk({tag, ".MUX_out"},    s_mux,           e_mux);
        chk({tag, ".write"},      {15'h0, s_wr},   {15'h0, e_wr});
        chk({tag, ".AC_out"},     AC_out,          m_ac);
        chk({tag, ".PC_out"},     PC_out,          m_pc);
        chk({tag, ".Z_Flag"},     {15'h0, Z_Flag}, {15'h0, m_z});
        chk({tag, ".out"},        out,             m_tr);
        chk({tag, ".ram_addr"},   ram_addr,        m_ar);
        chk({tag, ".counter_in"}, {10'h0, counter_in}, {10'h0, m_cnt});
    endtask

    task automatic run(input logic [5:0] ir, input string tag);
        apply(ir, 1'b0);
        check_model(tag);
    endtask

    typedef struct {
        logic [5:0]  ir;
        logic [3:0]  abus;
        logic [15:0] mux;
        logic        wr;
        logic [15:0] ac;
        logic [15:0] pc;
        logic        z;
    } vec_t;

    vec_t vecs [10];
    logic [5:0] aa_seq [21];

    initial begin
        rst = 1'b1;
        IR  = 6'b000000;

        vecs[0] = '{6'b000000, 4'h0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 1'b0};
        vecs[1] = '{6'b001001, 4'h9, 16'h0001, 1'b0, 16'h0001, 16'h0002, 1'b0};
        vecs[2] = '{6'b110111, 4'h0, 16'h0000, 1'b0, 16'h0002, 16'h0003, 1'b0};
        vecs[3] = '{6'b110111, 4'h0, 16'h0000, 1'b0, 16'h0003, 16'h0004, 1'b0};
        vecs[4] = '{6'b110111, 4'h0, 16'h0000, 1'b0, 16'h0004, 16'h0005, 1'b0};
        vecs[5] = '{6'b110111, 4'h0, 16'h0000, 1'b0, 16'h0005, 16'h0006, 1'b0};
        vecs[6] = '{6'b101011, 4'h0, 16'h0000, 1'b0, 16'h0005, 16'h0007, 1'b0};
        vecs[7] = '{6'b011011, 4'hB, 16'h0005, 1'b0, 16'h0000, 16'h0008, 1'b1};
        vecs[8] = '{6'b111001, 4'h9, 16'h0008, 1'b0, 16'h0000, 16'h0008, 1'b1};
        vecs[9] = '{6'b000000, 4'h0, 16'h0000, 1'b0, 16'h0000, 16'h0009, 1'b1};

        // AR := 3, AC := 1, then build 0xAA by doubling (STORE RB; ADD RB) and incrementing.
        aa_seq = '{6'b110000, 6'b110000, 6'b110000, 6'b110111,
                   6'b101100, 6'b010100, 6'b101100, 6'b010100, 6'b110111,
                   6'b101100, 6'b010100, 6'b101100, 6'b010100, 6'b110111,
                   6'b101100, 6'b010100, 6'b101100, 6'b010100, 6'b110111,
                   6'b101100, 6'b010100};

        // Reset state
        apply(6'b000000, 1'b1);
        chk("rst.AC_out", AC_out, 16'h0);
        chk("rst.PC_out", PC_out, 16'h0);
        chk("rst.Z_Flag", {15'h0, Z_Flag}, 16'h0);
        chk("rst.out", out, 16'h0);
        chk("rst.ram_addr", ram_addr, 16'h0);
        chk("rst.counter_in", {10'h0, counter_in}, 16'h0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].ir, 1'b0);
            chk($sformatf("vec%0d.A_bus", i), {12'h0, s_abus}, {12'h0, vecs[i].abus});
            chk($sformatf("vec%0d.MUX_out", i), s_mux, vecs[i].mux);
            chk($sformatf("vec%0d.write", i), {15'h0, s_wr}, {15'h0, vecs[i].wr});
            chk($sformatf("vec%0d.AC_out", i), AC_out, vecs[i].ac);
            chk($sformatf("vec%0d.PC_out", i), PC_out, vecs[i].pc);
            chk($sformatf("vec%0d.Z_Flag", i), {15'h0, Z_Flag}, {15'h0, vecs[i].z});
            chk($sformatf("vec%0d.counter_in", i), {10'h0, counter_in}, {10'h0, vecs[i].ir});
        end

        // Memory write / read round trip at AR=3 with AC=0xAA
        for (int i = 0; i < 21; i++) run(aa_seq[i], $sformatf("aa%0d", i));
        chk("mem.ram_addr", ram_addr, 16'h0003);
        chk("mem.AC_before_store", AC_out, 16'h00AA);
        apply(6'b101111, 1'b0);
        chk("mem.write_strobe", {15'h0, s_wr}, 16'h1);
        run(6'b110000, "mem.ar_bump");       // AR=4: different word reads 0
        run(6'b001111, "mem.read_other");
        chk("mem.other_word", AC_out, 16'h0000);
        run(6'b101000, "mem.ar_back");       // AC=0 -> AR=0
        run(6'b110000, "mem.ar1");
        run(6'b110000, "mem.ar2");
        run(6'b110000, "mem.ar3");
        apply(6'b001111, 1'b0);
        chk("mem.read_abus", {12'h0, s_abus}, 16'h000F);
        chk("mem.read_mux", s_mux, 16'h00AA);
        chk("mem.read_ac", AC_out, 16'h00AA);

        // Wraparound: AC=0xFFFF via 0 - 1, PC=0xFFFF via STORE PC
        run(6'b001010, "wrap.mov_dr");       // AC=DR=0, Z=1
        run(6'b110101, "wrap.inc_rc");       // RC=1
        run(6'b011101, "wrap.sub_rc");       // AC=FFFF, Z=0
        chk("wrap.ac_ffff", AC_out, 16'hFFFF);
        run(6'b101001, "wrap.store_pc");
        chk("wrap.pc_ffff", PC_out, 16'hFFFF);
        apply(6'b110111, 1'b0);              // INC AC
        chk("wrap.ac_zero", AC_out, 16'h0000);
        chk("wrap.z_unchanged", {15'h0, Z_Flag}, 16'h0);
        chk("wrap.pc_zero", PC_out, 16'h0000);
        run(6'b000000, "wrap.nop");
        apply(6'b111001, 1'b0);              // JMPZ not taken
        chk("jmpz_not_taken.pc", PC_out, 16'h0002);

        // Reset coincident with STORE MEM must not write
        run(6'b101000, "rstw.ar0");          // AC=0 -> AR=0
        run(6'b110111, "rstw.ac1");          // AC=1
        apply(6'b101111, 1'b1);
        chk("rstw.write_comb", {15'h0, s_wr}, 16'h1);
        chk("rstw.ac", AC_out, 16'h0);
        chk("rstw.pc", PC_out, 16'h0);
        chk("rstw.counter_in", {10'h0, counter_in}, 16'h0);
        apply(6'b001111, 1'b0);
        chk("rstw.mem_read", s_mux, 16'h0000);
        chk("rstw.ac_after", AC_out, 16'h0000);
        chk("rstw.counter_prev", {10'h0, counter_in}, 16'h000F);
        apply(6'b000000, 1'b0);
        chk("rstw.counter_nop", {10'h0, counter_in}, 16'h0000);

        // Randomized run against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [5:0] ir;
            logic       r;
            ir = 6'($urandom_range(0, 63));
            r  = ($urandom_range(0, 63) == 0);
            apply(ir, r);
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
